// File: rtl/result_stream_buffer.sv
// result_stream_buffer: elastic buffer between a free-running filter result
// stream (valid only, no backpressure) and a ready/valid consumer. Drops a
// programmable number of warm-up words after reset, buffers stalls in a FIFO,
// and counts words lost when the FIFO is full instead of stalling the source.
module result_stream_buffer #(
    parameter int OUT_W      = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int SKIP       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OUT_W-1:0]                in_data,
    input  logic                            in_valid,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overflow,
    output logic [15:0]                     drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [15:0]   SKIP_INIT = 16'(SKIP);
    localparam logic [15:0]   DROP_MAX  = 16'hFFFF;

    // Storage is data only; it is never reset, the pointers define validity.
    logic [OUT_W-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   skip_q, skip_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;

    logic run_phase;
    logic full;
    logic push;
    logic pop;
    logic drop;

    // Next-state logic: skip / push / drop / pop decisions and counter updates.
    always_comb begin
        run_phase  = (skip_q == 16'd0);
        full       = (level_q == FULL_LVL);
        pop        = (level_q != '0) && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = run_phase && in_valid && (!full || pop);
        drop       = run_phase && in_valid && full && !pop;

        skip_d     = skip_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // Warm-up words are discarded silently and are not counted as drops.
        if (in_valid && !run_phase) begin
            skip_d = skip_q - 16'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != DROP_MAX) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // Control state registers; reset restores an empty FIFO and reloads skip.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            skip_q     <= SKIP_INIT;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            skip_q     <= skip_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage write; suppressed during reset so the reset cycle ignores inputs.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Output view: head word when non-empty, zeros otherwise (no bypass path).
    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = '0;
        if (out_valid) begin
            out_data = mem[rd_ptr_q];
        end
        level      = level_q;
        overflow   = overflow_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_result_stream_buffer.sv
// Directed bench for result_stream_buffer: one instance with SKIP=0 for the
// flow/overflow/wrap scenarios and one with SKIP=3 for the warm-up discard.
module tb_result_stream_buffer;

    logic        clk;
    logic        rst;
    logic [13:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [13:0] out_data;
    logic        out_valid;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    logic [13:0] out_data3;
    logic        out_valid3;
    logic [4:0]  level3;
    logic        overflow3;
    logic [15:0] drop_count3;

    int vectors    = 0;
    int miscompares = 0;

    result_stream_buffer #(.OUT_W(14), .FIFO_DEPTH(16), .SKIP(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    result_stream_buffer #(.OUT_W(14), .FIFO_DEPTH(16), .SKIP(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .level     (level3),
        .overflow  (overflow3),
        .drop_count(drop_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int          got[$];
        int          q[$];
        int          drops;
        logic        rdy;
        logic        pop;
        logic        prev_stall;
        logic [13:0] prev;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_level",    32'(level),      0);
        chk("rst_valid",    32'(out_valid),  0);
        chk("rst_data",     32'(out_data),   0);
        chk("rst_overflow", 32'(overflow),   0);
        chk("rst_drops",    32'(drop_count), 0);
        rst = 1'b0;

        // Warm-up skip on dut3 (and basic streaming on dut0): push 10..15
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 6);
            in_data  = 14'(10 + i);
            tick();
            if (out_valid3) got.push_back(int'(out_data3));
        end
        in_valid = 1'b0;
        chk("skip_count",    got.size(), 3);
        chk("skip_w0",       got[0], 13);
        chk("skip_w1",       got[1], 14);
        chk("skip_w2",       got[2], 15);
        chk("skip_overflow", 32'(overflow3), 0);

        // Basic flow: push 1, 2, 3 with ready held high
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(i);
            tick();
            chk("flow_valid", 32'(out_valid), 1);
            chk("flow_data",  32'(out_data),  i);
            chk("flow_level", 32'(level),     1);
        end
        in_valid = 1'b0;
        tick();
        chk("flow_empty", 32'(out_valid),  0);
        chk("flow_zero",  32'(out_data),   0);
        chk("flow_drops", 32'(drop_count), 0);

        // Fill and overflow: 20 words into 16 entries with ready low
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_level",    32'(level),      16);
        chk("fill_overflow", 32'(overflow),   1);
        chk("fill_drops",    32'(drop_count), 4);
        chk("fill_head",     32'(out_data),   0);
        tick();
        chk("fill_stable",   32'(out_data),   0);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("fill_drain", 32'(out_data), j);
            tick();
        end
        chk("fill_empty_level", 32'(level),     0);
        chk("fill_empty_valid", 32'(out_valid), 0);
        chk("fill_sticky",      32'(overflow),  1);

        // Full FIFO with simultaneous push and pop
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(i);
            tick();
        end
        chk("fpp_level_pre", 32'(level), 16);
        in_valid  = 1'b1;
        in_data   = 14'd99;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fpp_level",    32'(level),      16);
        chk("fpp_drops",    32'(drop_count), 0);
        chk("fpp_overflow", 32'(overflow),   0);
        for (int j = 1; j <= 15; j++) begin
            chk("fpp_drain", 32'(out_data), j);
            tick();
        end
        chk("fpp_last", 32'(out_data), 99);
        tick();
        chk("fpp_empty", 32'(level), 0);

        // Wrap and stall: 1000 words, random ready, queue model
        rst = 1'b1; tick(); rst = 1'b0;
        drops      = 0;
        prev_stall = 1'b0;
        prev       = '0;
        for (int n = 0; n < 1000; n++) begin
            rdy       = 1'($urandom_range(0, 1));
            out_ready = rdy;
            in_valid  = 1'b1;
            in_data   = 14'(n);
            chk("rnd_valid", 32'(out_valid), (q.size() != 0) ? 1 : 0);
            chk("rnd_level", 32'(level), q.size());
            if (q.size() != 0) chk("rnd_data", 32'(out_data), q[0]);
            if (prev_stall) chk("rnd_stable", 32'(out_data), 32'(prev));
            prev_stall = (q.size() != 0) && !rdy;
            prev       = out_data;
            pop        = (q.size() != 0) && rdy;
            if (pop) void'(q.pop_front());
            if (q.size() == 16) drops++;
            else q.push_back(n);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            chk("rnd_drain", 32'(out_data), q[0]);
            void'(q.pop_front());
            tick();
        end
        chk("rnd_model_empty", q.size(), 0);
        chk("rnd_level_end",   32'(level),      0);
        chk("rnd_drops",       32'(drop_count), drops);
        chk("rnd_overflow",    32'(overflow),   (drops > 0) ? 1 : 0);

        // Reset mid-stream with five words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(200 + i);
            tick();
        end
        chk("mid_level_pre", 32'(level), 5);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 14'd555;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_valid",    32'(out_valid),  0);
        chk("mid_level",    32'(level),      0);
        chk("mid_overflow", 32'(overflow),   0);
        chk("mid_drops",    32'(drop_count), 0);
        chk("mid_level3",   32'(level3),     0);
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(i);
            tick();
        end
        chk("mid_skip_level3", 32'(level3), 0);
        in_data = 14'd4;
        tick();
        in_valid = 1'b0;
        chk("mid_skip_valid3", 32'(out_valid3), 1);
        chk("mid_skip_data3",  32'(out_data3),  4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
